ps2_host_tx: RTL

- Host-to-device PS/2 command transmitter for keyboard and mouse ports.
- Sends one byte to the device: LED update, typematic rate, reset, enable scanning.
- Performs the full host request sequence: clock inhibit, start bit, device-clocked data, odd parity, stop bit and acknowledge check.
- Sits beside the keyboard receiver in the `CLOCK_50` domain. Shares the open-drain `PS2_CLK`/`PS2_DAT` pair. The receiver must ignore the bus while `busy` is high.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state enum, default bus timing at 50 MHz
// and the odd-parity helper used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_WAIT_FIRST,
    ST_SHIFT,
    ST_WAIT_IDLE,
    ST_ERROR
  } ps2_tx_state_t;

  localparam int PS2_CNT_W         = 20;
  localparam int PS2_INHIBIT_100US = 5000;
  localparam int PS2_START_1US     = 50;
  localparam int PS2_TIMEOUT_15MS  = 750000;
  localparam int PS2_TIMEOUT_2MS   = 100000;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/handshake bundle between a PS/2 command source (master) and the
// host transmitter (slave).
interface ps2_host_tx_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic       error_no_ack;

  modport master (
    output the_command, send_command,
    input  busy, command_was_sent, error_communication_timed_out, error_no_ack
  );

  modport slave (
    input  the_command, send_command,
    output busy, command_was_sent, error_communication_timed_out, error_no_ack
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one open-drain PS/2 line plus a 1->0 edge detector
// on the synchronized value. Resets to the idle (high) bus level.
module ps2_sync_edge (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic line,
  output logic line_sync,
  output logic fall
);
  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= line;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign line_sync = sync_reg;
  assign fall      = prev_reg & ~sync_reg;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start, device-clocked data,
// odd parity, stop, ack. Define PS2_TX_ACK_CHECK_EN to flag a missing ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_100US,
  parameter int START_CYCLES   = PS2_START_1US,
  parameter int FIRST_TIMEOUT  = PS2_TIMEOUT_15MS,
  parameter int XFER_TIMEOUT   = PS2_TIMEOUT_2MS
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ps2_host_tx_if.slave cmd,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DAT
);
  localparam logic [PS2_CNT_W-1:0] INHIBIT_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_CNT_W-1:0] START_LAST   = PS2_CNT_W'(START_CYCLES - 1);
  localparam logic [PS2_CNT_W-1:0] FIRST_LAST   = PS2_CNT_W'(FIRST_TIMEOUT - 1);
  localparam logic [PS2_CNT_W-1:0] XFER_LAST    = PS2_CNT_W'(XFER_TIMEOUT - 1);

  ps2_tx_state_t        state_reg, state_next;
  logic [PS2_CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]           bit_reg, bit_next;
  logic [7:0]           byte_reg, byte_next;
  logic                 parity_reg, parity_next;
  logic                 sent_reg, sent_next;
  logic                 clk_low, dat_low, busy, timed_out;
  logic                 clk_sync, clk_fall, dat_sync, dat_fall_unused;

  ps2_sync_edge u_clk_sync (.CLOCK_50(CLOCK_50), .reset(reset), .line(PS2_CLK),
                            .line_sync(clk_sync), .fall(clk_fall));
  ps2_sync_edge u_dat_sync (.CLOCK_50(CLOCK_50), .reset(reset), .line(PS2_DAT),
                            .line_sync(dat_sync), .fall(dat_fall_unused));

  // Saturating so a stuck bus can never wrap the timeout comparisons.
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + PS2_CNT_W'(1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      byte_reg   <= '0;
      parity_reg <= 1'b0;
      sent_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      byte_reg   <= byte_next;
      parity_reg <= parity_next;
      sent_reg   <= sent_next;
    end
  end

`ifdef PS2_TX_ACK_CHECK_EN
  logic no_ack_reg, no_ack_next;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) no_ack_reg <= 1'b0;
    else       no_ack_reg <= no_ack_next;
  end
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_inc;
    bit_next    = bit_reg;
    byte_next   = byte_reg;
    parity_next = parity_reg;
    sent_next   = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    no_ack_next = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (cmd.send_command) begin
          byte_next   = cmd.the_command;
          parity_next = ps2_odd_parity(cmd.the_command);
          state_next  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: if (cnt_reg >= INHIBIT_LAST) begin
        state_next = ST_START;
        cnt_next   = '0;
      end
      ST_START: if (cnt_reg >= START_LAST) begin
        state_next = ST_WAIT_FIRST;
        cnt_next   = '0;
      end
      ST_WAIT_FIRST: begin
        // The transfer timeout starts over once the device begins clocking.
        if (clk_fall) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
          bit_next   = '0;
        end else if (cnt_reg >= FIRST_LAST) begin
          state_next = ST_ERROR;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg >= XFER_LAST) begin
          state_next = ST_ERROR;
        end else if (clk_fall) begin
          bit_next = bit_reg + 4'd1;
          if (bit_reg == 4'd9) begin
`ifdef PS2_TX_ACK_CHECK_EN
            if (dat_sync) begin
              no_ack_next = 1'b1;
              state_next  = ST_IDLE;
            end else begin
              state_next = ST_WAIT_IDLE;
            end
`else
            state_next = ST_WAIT_IDLE;
`endif
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (cnt_reg >= XFER_LAST) begin
          state_next = ST_ERROR;
        end else if (clk_sync && dat_sync) begin
          sent_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_low   = 1'b0;
    dat_low   = 1'b0;
    busy      = (state_reg != ST_IDLE) && (state_reg != ST_ERROR);
    timed_out = (state_reg == ST_ERROR);
    case (state_reg)
      ST_INHIBIT:    clk_low = 1'b1;
      ST_START: begin
        clk_low = 1'b1;
        dat_low = 1'b1;
      end
      ST_WAIT_FIRST: dat_low = 1'b1;
      ST_SHIFT: begin
        // Bit counts 0..7 carry data LSB first, 8 carries parity, 9 is the released stop bit.
        if (bit_reg < 4'd8)       dat_low = ~byte_reg[bit_reg[2:0]];
        else if (bit_reg == 4'd8) dat_low = ~parity_reg;
      end
      default: ;
    endcase
  end

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign cmd.busy                          = busy;
  assign cmd.command_was_sent              = sent_reg;
  assign cmd.error_communication_timed_out = timed_out;
`ifdef PS2_TX_ACK_CHECK_EN
  assign cmd.error_no_ack = no_ack_reg;
`else
  assign cmd.error_no_ack = 1'b0;
`endif
endmodule
